// File: rtl/fpu_lzd_pipe_if.sv
// Handshake and result bundle for fpu_lzd_pipe.
// The out_norm member and its modport entries are present only when
// FPU_LZD_NORM_EN is defined.
//
// Valid/ready semantics: a word moves across a channel on a rising clk edge
// where valid && ready are both high. The producer holds valid and data
// steady until that edge and never waits for ready before raising valid.
// The consumer may raise or lower ready freely. On the input channel
// in_ready is a combinational function of pipeline occupancy and out_ready.
interface fpu_lzd_pipe_if #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_pos;
    logic             out_val;
`ifdef FPU_LZD_NORM_EN
    logic [WIDTH-1:0] out_norm;

    // Upstream/downstream side: supplies operands and consumes results.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_pos, out_val, out_norm
    );

    // Pipeline side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_pos, out_val, out_norm
    );
`else
    // Upstream/downstream side: supplies operands and consumes results.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_pos, out_val
    );

    // Pipeline side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_pos, out_val
    );
`endif
endinterface

// File: rtl/fpu_lzd_pipe.sv
// Two-stage pipelined leading-zero detector with valid/ready flow control.
//   S1: the operand is split into GROUP-bit slices (slice 0 holds the MSBs);
//       each slice's leading-zero count and nonzero flag are registered.
//   S2: the most-significant nonzero slice is selected and the full count
//       g*GROUP + count[g] is registered, along with out_val.
// Optional feature macro FPU_LZD_NORM_EN: S1 also registers the operand and
// S2 registers out_norm = operand << out_pos (zero-filled). Without the macro
// the operand register and out_norm are absent.
// Latency is two cycles; throughput is one operand per cycle.
module fpu_lzd_pipe #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8,
    localparam int CW   = $clog2(WIDTH)
) (
    input logic           clk,
    input logic           rst,
    fpu_lzd_pipe_if.slave bus
);

    localparam int NG = WIDTH / GROUP;   // number of slices
    localparam int GW = $clog2(GROUP);   // width of a per-slice count

    // Leading-zero count of one slice. An all-zero slice returns 0; S2 never
    // uses the count of a zero slice because its nonzero flag is clear.
    function automatic logic [GW-1:0] grp_lzc(input logic [GROUP-1:0] v);
        logic [GW-1:0] c;
        logic          found;
        c     = '0;
        found = 1'b0;
        for (int i = GROUP - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                c     = GW'(GROUP - 1 - i);
                found = 1'b1;
            end
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic                   s1_valid_q, s1_valid_d;
    logic [NG-1:0][GW-1:0]  s1_cnt_q,   s1_cnt_d;
    logic [NG-1:0]          s1_nz_q,    s1_nz_d;

    logic                   s2_valid_q, s2_valid_d;
    logic [CW-1:0]          s2_pos_q,   s2_pos_d;
    logic                   s2_val_q,   s2_val_d;

`ifdef FPU_LZD_NORM_EN
    logic [WIDTH-1:0]       s1_data_q,  s1_data_d;
    logic [WIDTH-1:0]       s2_norm_q,  s2_norm_d;
    logic [WIDTH-1:0]       comb_norm;
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s2_adv;
    logic s1_adv;
    logic in_fire;
    logic s2_load;

    // A stage may advance when it is empty or when the stage after it is
    // advancing; this lets S2 drain and S1 refill in the same cycle.
    always_comb begin
        s2_adv  = !s2_valid_q || bus.out_ready;
        s1_adv  = !s1_valid_q || s2_adv;
        in_fire = bus.in_valid && s1_adv;
        s2_load = s2_adv && s1_valid_q;
    end

    assign bus.in_ready = s1_adv;

    // ------------------------------------------------------------------
    // Stage 1: per-slice count and nonzero flag
    // ------------------------------------------------------------------
    logic [NG-1:0][GW-1:0] grp_cnt;
    logic [NG-1:0]         grp_nz;

    // Slice g covers bits [WIDTH-1-g*GROUP -: GROUP], so slice 0 is the MSBs.
    always_comb begin
        grp_cnt = '0;
        grp_nz  = '0;
        for (int g = 0; g < NG; g++) begin
            grp_cnt[g] = grp_lzc(bus.in_data[WIDTH-1-g*GROUP -: GROUP]);
            grp_nz[g]  = |bus.in_data[WIDTH-1-g*GROUP -: GROUP];
        end
    end

    // S1 next state: valid follows in_valid whenever S1 advances; the data
    // registers only load on an actual transfer so they stay quiet otherwise.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cnt_d   = s1_cnt_q;
        s1_nz_d    = s1_nz_q;
`ifdef FPU_LZD_NORM_EN
        s1_data_d  = s1_data_q;
`endif
        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
        end
        if (in_fire) begin
            s1_cnt_d  = grp_cnt;
            s1_nz_d   = grp_nz;
`ifdef FPU_LZD_NORM_EN
            s1_data_d = bus.in_data;
`endif
        end
    end

    // S1 registers; reset empties the stage and discards any operand in it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_cnt_q   <= '0;
            s1_nz_q    <= '0;
`ifdef FPU_LZD_NORM_EN
            s1_data_q  <= '0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_nz_q    <= s1_nz_d;
`ifdef FPU_LZD_NORM_EN
            s1_data_q  <= s1_data_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: combine slices
    // ------------------------------------------------------------------
    logic [CW-1:0] comb_pos;
    logic          comb_val;

    // Scan from the least-significant slice upward so the last hit written
    // is the most-significant nonzero slice. An all-zero operand leaves
    // pos = 0 and val = 0.
    always_comb begin
        comb_pos = '0;
        comb_val = 1'b0;
        for (int g = NG - 1; g >= 0; g--) begin
            if (s1_nz_q[g]) begin
                comb_pos = CW'(g * GROUP) + CW'(s1_cnt_q[g]);
                comb_val = 1'b1;
            end
        end
    end

`ifdef FPU_LZD_NORM_EN
    // Normalise by the final count; a zero operand shifts to zero.
    always_comb begin
        comb_norm = s1_data_q << comb_pos;
    end
`endif

    // S2 next state: results only change when a new operand moves in, so
    // they hold while stalled and while the output is idle.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_pos_d   = s2_pos_q;
        s2_val_d   = s2_val_q;
`ifdef FPU_LZD_NORM_EN
        s2_norm_d  = s2_norm_q;
`endif
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            s2_pos_d  = comb_pos;
            s2_val_d  = comb_val;
`ifdef FPU_LZD_NORM_EN
            s2_norm_d = comb_norm;
`endif
        end
    end

    // S2 registers; reset clears the valid flag and the visible results.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_pos_q   <= '0;
            s2_val_q   <= 1'b0;
`ifdef FPU_LZD_NORM_EN
            s2_norm_q  <= '0;
`endif
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_pos_q   <= s2_pos_d;
            s2_val_q   <= s2_val_d;
`ifdef FPU_LZD_NORM_EN
            s2_norm_q  <= s2_norm_d;
`endif
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_pos   = s2_pos_q;
    assign bus.out_val   = s2_val_q;
`ifdef FPU_LZD_NORM_EN
    assign bus.out_norm  = s2_norm_q;
`endif

endmodule

// File: tb/tb_fpu_lzd_pipe.sv
// Testbench for fpu_lzd_pipe (WIDTH=32, GROUP=8). Covers out_norm only when
// FPU_LZD_NORM_EN is defined.
module tb_fpu_lzd_pipe;

    localparam int WIDTH = 32;
    localparam int GROUP = 8;
    localparam int CW    = $clog2(WIDTH);
`ifdef FPU_LZD_NORM_EN
    localparam int EW    = 1 + CW + WIDTH;
`else
    localparam int EW    = 1 + CW;
`endif
    localparam int NV    = 12;
    localparam int N_RAND = 10000;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_lzd_pipe_if #(.WIDTH(WIDTH)) bus ();

    fpu_lzd_pipe #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ------------------------------------------------------------------
    // Counters and check helper
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-serial reference: last set bit seen scanning upward is the MSB one.
    function automatic logic [EW-1:0] ref_model(input logic [WIDTH-1:0] d);
        logic [CW-1:0] p;
        logic          v;
        p = '0;
        v = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) begin
                p = CW'(WIDTH - 1 - i);
                v = 1'b1;
            end
        end
`ifdef FPU_LZD_NORM_EN
        return {v, p, d << p};
`else
        return {v, p};
`endif
    endfunction

    function automatic logic [EW-1:0] act_pack();
`ifdef FPU_LZD_NORM_EN
        return {bus.out_val, bus.out_pos, bus.out_norm};
`else
        return {bus.out_val, bus.out_pos};
`endif
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard: sampled on the falling edge, where all signals are stable
    // ------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    logic          hold_pend = 1'b0;
    logic [EW:0]   hold_snap;
    int            n_out = 0;

    always @(negedge clk) begin
        if (hold_pend) begin
            check("stall_hold", {bus.out_valid, act_pack()}, hold_snap);
        end
        hold_pend = 1'b0;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got result %0h with no operand pending at %0t",
                             act_pack(), $time);
                end else begin
                    total--;
                    check("sb_result", act_pack(), exp_q.pop_front());
                end
                n_out++;
            end
            if (bus.out_valid && !bus.out_ready) begin
                hold_pend = 1'b1;
                hold_snap = {1'b1, act_pack()};
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_model(bus.in_data));
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] pick_data();
        int r;
        int k;
        r = $urandom_range(0, 9);
        k = $urandom_range(0, WIDTH - 1);
        if (r == 0)      return '0;
        else if (r <= 4) return WIDTH'(1) << k;
        else             return WIDTH'($urandom) >> k;
    endfunction

    // ------------------------------------------------------------------
    // Directed vectors (hand-computed)
    // ------------------------------------------------------------------
    typedef struct {
        logic [WIDTH-1:0] data;
        logic [CW-1:0]    pos;
        logic             val;
        logic [WIDTH-1:0] norm;
    } vec_t;

    vec_t vec [NV];

    initial begin
        int rcyc;
        int start_out;

        vec[0]  = '{32'h0000_8000, 5'd16, 1'b1, 32'h8000_0000};
        vec[1]  = '{32'h0000_0000, 5'd0,  1'b0, 32'h0000_0000};
        vec[2]  = '{32'hFFFF_FFFF, 5'd0,  1'b1, 32'hFFFF_FFFF};
        vec[3]  = '{32'h0000_0001, 5'd31, 1'b1, 32'h8000_0000};
        vec[4]  = '{32'h8000_0000, 5'd0,  1'b1, 32'h8000_0000};
        vec[5]  = '{32'h00FF_0000, 5'd8,  1'b1, 32'hFF00_0000};
        vec[6]  = '{32'h0100_0000, 5'd7,  1'b1, 32'h8000_0000};
        vec[7]  = '{32'h0000_0100, 5'd23, 1'b1, 32'h8000_0000};
        vec[8]  = '{32'h1234_5678, 5'd3,  1'b1, 32'h91A2_B3C0};
        vec[9]  = '{32'h0000_00F0, 5'd24, 1'b1, 32'hF000_0000};
        vec[10] = '{32'h0007_0000, 5'd13, 1'b1, 32'hE000_0000};
        vec[11] = '{32'h0000_0003, 5'd30, 1'b1, 32'hC000_0000};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_pos",   bus.out_pos,   0);
        check("rst_out_val",   bus.out_val,   0);
        check("rst_in_ready",  bus.in_ready,  1);
`ifdef FPU_LZD_NORM_EN
        check("rst_out_norm",  bus.out_norm,  0);
`endif

        // Table: one operand at a time, latency and values
        for (int i = 0; i < NV; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vec[i].data;
            #1;
            check("tbl_in_ready", bus.in_ready, 1);
            cyc();
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
            #1;
            check("tbl_lat1_idle", bus.out_valid, 0);
            cyc();
            #1;
            check("tbl_lat2_valid", bus.out_valid, 1);
            check("tbl_pos", bus.out_pos, vec[i].pos);
            check("tbl_val", bus.out_val, vec[i].val);
`ifdef FPU_LZD_NORM_EN
            check("tbl_norm", bus.out_norm, vec[i].norm);
`endif
            cyc();
            #1;
            check("tbl_drained", bus.out_valid, 0);
        end

        // Back-to-back 0x1, 0x2, 0x4 -> 31, 30, 29 on consecutive cycles
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1;
        cyc();
        bus.in_data  = 32'h2;
        cyc();
        bus.in_data  = 32'h4;
        #1;
        check("b2b_valid0", bus.out_valid, 1);
        check("b2b_pos0",   bus.out_pos,   31);
        cyc();
        bus.in_valid = 1'b0;
        #1;
        check("b2b_valid1", bus.out_valid, 1);
        check("b2b_pos1",   bus.out_pos,   30);
        cyc();
        #1;
        check("b2b_valid2", bus.out_valid, 1);
        check("b2b_pos2",   bus.out_pos,   29);
        cyc();
        #1;
        check("b2b_done", bus.out_valid, 0);

        // Stall: out_ready low for 5 cycles with three operands offered
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0001_0000;   // pos 15
        #1;
        check("stall_rdy_a", bus.in_ready, 1);
        cyc();
        bus.in_data   = 32'h0000_0010;   // pos 27
        #1;
        check("stall_rdy_b", bus.in_ready, 1);
        cyc();
        bus.in_data   = 32'h4000_0000;   // pos 1
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_rdy_low", bus.in_ready, 0);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_out_pos", bus.out_pos, 15);
            cyc();
        end
        bus.out_ready = 1'b1;
        #1;
        check("stall_release_rdy", bus.in_ready, 1);
        check("stall_first_pos", bus.out_pos, 15);
        cyc();
        bus.in_valid = 1'b0;
        #1;
        check("stall_second_valid", bus.out_valid, 1);
        check("stall_second_pos", bus.out_pos, 27);
        cyc();
        #1;
        check("stall_third_valid", bus.out_valid, 1);
        check("stall_third_pos", bus.out_pos, 1);
        cyc();
        #1;
        check("stall_done", bus.out_valid, 0);

        // Reset with both stages full; in_valid during reset is ignored
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_0400;
        cyc();
        bus.in_data   = 32'h0020_0000;
        cyc();
        bus.in_data   = 32'h0000_FFFF;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        #1;
        check("mrst_full_before", bus.out_valid, 1);
        cyc();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("mrst_out_valid", bus.out_valid, 0);
        check("mrst_in_ready",  bus.in_ready,  1);
        check("mrst_out_val",   bus.out_val,   0);
        check("mrst_out_pos",   bus.out_pos,   0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            check("mrst_no_stale", bus.out_valid, 0);
        end

        // Random traffic against the reference model via the scoreboard
        rcyc      = 0;
        start_out = n_out;
        while ((n_out - start_out) < N_RAND && rcyc < 60000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = pick_data();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cyc();
            rcyc++;
        end
        check("rand_transfers_done", ((n_out - start_out) >= N_RAND), 1);

        // Drain
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) cyc();
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_lzd_pipe.md
FPU_LZD_PIPE -- requirements
Module: fpu_lzd_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; power of two, >= 8.
REQ-002 SHALL have parameter GROUP, default 8: stage-1 group width; power of two, >= 2, divides WIDTH.
REQ-003 SHALL define CW = log2(WIDTH) as the width of the count output.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  upstream operand valid.
REQ-007 SHALL have port in_ready  output  1  block accepts an operand this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  operand; MSB is bit WIDTH-1.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port out_pos  output  CW  leading-zero count of the operand.
REQ-012 SHALL have port out_val  output  1  operand contained at least one set bit.
REQ-013 SHALL have port out_norm  output  WIDTH  normalised operand; present only with FPU_LZD_NORM_EN.

Function
REQ-014 SHALL be a two-stage valid/ready pipeline: S1 registers per-group counts and valids; S2 registers the combined result.
REQ-015 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-016 SHALL give latency 2 cycles from input transfer to out_valid when not stalled, with throughput 1 operand per cycle.
REQ-017 SHALL define s2_adv = !s2_valid || out_ready and s1_adv = !s1_valid || s2_adv, and drive in_ready = s1_adv combinationally.
REQ-018 SHALL have S1, for each GROUP-bit slice, register the group leading-zero count (log2(GROUP) bits) and the group-nonzero flag.
REQ-019 SHALL have S2 select the most-significant nonzero group g (group 0 is the MSB group) and set out_pos = g*GROUP + count of group g.
REQ-020 SHALL set out_val = 1 and out_pos in 0..WIDTH-1 for nonzero in_data.
REQ-021 SHALL set out_val = 0 and out_pos = 0 for in_data == 0.
REQ-022 SHALL hold out_pos, out_val, out_norm and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL lose no operand and duplicate no operand under arbitrary stall patterns; results leave in input order.
REQ-024 SHALL, on a simultaneous S2 drain and S1 refill in one cycle, accept the new operand without a bubble.
REQ-025 SHALL leave out_* data values unspecified, but stable, while out_valid = 0.

Reset
REQ-026 SHALL, while rst = 1 at a clock edge, clear the S1 and S2 valid flags, out_pos, out_val and out_norm to 0.
REQ-027 SHALL drive in_ready = 1 in the first cycle after reset release.
REQ-028 SHALL discard in-flight operands when reset is asserted mid-operation; none emerge afterward.
REQ-029 SHALL ignore in_valid during any cycle in which rst = 1.

Configuration
REQ-030 SHALL, with macro FPU_LZD_NORM_EN defined, register S1 in_data alongside the group counts and provide out_norm = in_data << out_pos (zero-fill) from S2, with no change in latency.
REQ-031 SHALL, with FPU_LZD_NORM_EN undefined, omit the out_norm port and the S1 operand register; all other behaviour SHALL be identical.

Verification
REQ-032 SHALL cover: WIDTH=32, GROUP=8, out_ready=1; in_data 0x0000_8000 at cycle 0 -> out_valid at cycle 2, out_pos=16, out_val=1, out_norm=0x8000_0000.
REQ-033 SHALL cover: in_data 0x0000_0000 -> out_pos=0, out_val=0, out_norm=0; in_data 0xFFFF_FFFF -> out_pos=0, out_val=1.
REQ-034 SHALL cover: back-to-back 0x1, 0x2, 0x4 with out_ready=1 -> out_pos 31, 30, 29 on three consecutive cycles.
REQ-035 SHALL cover: out_ready=0 for 5 cycles with 3 operands offered -> in_ready falls after 2 accepted, outputs held; out_ready=1 -> results in order, no loss.
REQ-036 SHALL cover: rst asserted for 1 cycle with both stages valid -> out_valid=0 next cycle, in_ready=1, no stale result later.
REQ-037 SHALL cover: random in_data with random in_valid/out_ready, 10k transfers, against a reference leading-zero model -> all match.
